// File: rtl/tile_pkg.sv
// Shared types and constants for the background tile fetcher: FSM states, char-word fields,
// SRAM wait count and FIFO entry packing.
package tile_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMapWait,
        StMapRd,
        StTileWait,
        StTileRd,
        StPush,
        StDone
    } state_e;

    localparam int unsigned TILE_ID_LSB = 0;
    localparam int unsigned TILE_ID_MSB = 8;
    localparam int unsigned HFLIP_BIT   = 9;
    localparam int unsigned VFLIP_BIT   = 10;
    localparam int unsigned PAL_LSB     = 12;
    localparam int unsigned PAL_MSB     = 15;

    // Cycles an SRAM address is held before ram_din is valid for capture.
    localparam int unsigned SRAM_WAIT_CYCLES = 1;

    function automatic logic [15:0] pack_fifo_data(input logic [3:0] pal, input logic [3:0] pix);
        return {8'h00, pal, pix};
    endfunction

endpackage

// File: rtl/tile_row_shifter.sv
// Holds one tile row (WPR pattern words, word 0 most significant) and presents pixel px,
// MSB first. Under TILE_FLIP_EN the hflip input reverses the 8-pixel order.
module tile_row_shifter
    import tile_pkg::*;
#(
    parameter int unsigned BPP = 4
) (
    input  logic        clk100,
    input  logic        reset,
    input  logic        load_i,
    input  logic        word_sel_i,
    input  logic [15:0] din_i,
    input  logic        hflip_i,
    input  logic [2:0]  px_i,
    output logic [3:0]  pix_o
);

    localparam int unsigned WPR   = BPP / 2;
    localparam int unsigned ROW_W = 16 * WPR;

    logic [ROW_W-1:0] row_q, row_d, row_load, row_shift;
    logic [2:0]       px_sel;

    if (WPR == 1) begin : g_one_word
        always_comb row_load = din_i;
    end else begin : g_two_words
        always_comb row_load = word_sel_i ? {row_q[ROW_W-1 -: 16], din_i} : {din_i, row_q[15:0]};
    end

    assign row_d = load_i ? row_load : row_q;

    always_ff @(posedge clk100) begin
        if (reset) begin
            row_q <= '0;
        end else begin
            row_q <= row_d;
        end
    end

`ifdef TILE_FLIP_EN
    assign px_sel = hflip_i ? ~px_i : px_i;
`else
    assign px_sel = px_i;
    logic unused_hflip;
    assign unused_hflip = hflip_i;
`endif

    logic unused_word_sel;
    assign unused_word_sel = word_sel_i;

    always_comb begin
        row_shift = row_q << (32'(px_sel) * BPP);
        pix_o     = 4'(row_shift[ROW_W-1 -: BPP]);
    end

endmodule

// File: rtl/tile_fetch_engine.sv
// Background line fetcher: walks one character-map row, fetches each tile's pattern words and
// pushes one FIFO entry per pixel. Define TILE_FLIP_EN to honour char bits 9/10 as h/v flip.
module tile_fetch_engine
    import tile_pkg::*;
#(
    parameter int unsigned BPP            = 4,
    parameter int unsigned TILES_PER_LINE = 100,
    parameter int unsigned TILE_ROWS      = 8,
    parameter int unsigned MAP_STRIDE     = 128,
    parameter logic [17:0] MAP_BASE       = 18'h00000,
    parameter logic [17:0] TILE_BASE      = 18'h20000
) (
    input  logic        clk100,
    input  logic        reset,
    input  logic        start,
    input  logic [9:0]  vpos,
    output logic        busy,
    output logic        line_done,
    output logic [17:0] ram_addr,
    input  logic [15:0] ram_din,
    output logic        ram_ce,
    output logic        ram_oe,
    output logic        ram_we,
    output logic        ram_lb,
    output logic        ram_hb,
    output logic [15:0] fifo_data,
    output logic        fifo_wrreq,
    input  logic        fifo_full
);

    localparam int unsigned WPR   = BPP / 2;
    localparam int unsigned COL_W = (TILES_PER_LINE > 1) ? $clog2(TILES_PER_LINE) : 1;

    state_e           state_q, state_d;
    logic [9:0]       vpos_q, vpos_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             word_q, word_d;
    logic [2:0]       px_q, px_d;
    logic [15:0]      char_q, char_d;
    logic [17:0]      addr_q, addr_d;
    logic [1:0]       wait_q, wait_d;

    logic             wait_last, last_col, last_word;
    logic [9:0]       map_vpos;
    logic [COL_W-1:0] map_col;
    logic [17:0]      map_addr, tile_addr;
    logic [15:0]      tile_char;
    logic             tile_word;
    logic [31:0]      row_term;
    logic [3:0]       pix;

    assign wait_last = (wait_q == 2'(SRAM_WAIT_CYCLES - 1));
    assign last_col  = (col_q == COL_W'(TILES_PER_LINE - 1));
    assign last_word = (32'(word_q) == WPR - 1);

    // In IDLE the address targets column 0 of the incoming vpos; later it targets the next column.
    always_comb begin
        map_vpos = (state_q == StIdle) ? vpos : vpos_q;
        map_col  = (state_q == StIdle) ? '0 : col_q + 1'b1;
        map_addr = 18'(32'(MAP_BASE) + (32'(map_vpos) / TILE_ROWS) * MAP_STRIDE + 32'(map_col));

        tile_char = (state_q == StMapRd) ? ram_din : char_q;
        tile_word = (state_q == StMapRd) ? 1'b0 : word_q + 1'b1;
        row_term  = 32'(vpos_q) % TILE_ROWS;
`ifdef TILE_FLIP_EN
        if (tile_char[VFLIP_BIT]) begin
            row_term = TILE_ROWS - 1 - row_term;
        end
`endif
        tile_addr = 18'(32'(TILE_BASE) + 32'(tile_char[TILE_ID_MSB:TILE_ID_LSB]) * TILE_ROWS * WPR
                        + row_term * WPR + 32'(tile_word));
    end

    logic unused_char_bits;
    assign unused_char_bits = ^tile_char[15:9];

    always_comb begin
        state_d = state_q;
        vpos_d  = vpos_q;
        col_d   = col_q;
        word_d  = word_q;
        px_d    = px_q;
        char_d  = char_q;
        addr_d  = addr_q;
        wait_d  = '0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    vpos_d  = vpos;
                    col_d   = '0;
                    addr_d  = map_addr;
                    state_d = StMapWait;
                end
            end
            StMapWait: begin
                if (wait_last) state_d = StMapRd;
                else           wait_d  = wait_q + 1'b1;
            end
            StMapRd: begin
                char_d  = ram_din;
                word_d  = 1'b0;
                addr_d  = tile_addr;
                state_d = StTileWait;
            end
            StTileWait: begin
                if (wait_last) state_d = StTileRd;
                else           wait_d  = wait_q + 1'b1;
            end
            StTileRd: begin
                if (!last_word) begin
                    word_d  = word_q + 1'b1;
                    addr_d  = tile_addr;
                    state_d = StTileWait;
                end else begin
                    px_d    = '0;
                    state_d = StPush;
                end
            end
            StPush: begin
                if (!fifo_full) begin
                    if (px_q == 3'd7) begin
                        if (last_col) begin
                            state_d = StDone;
                        end else begin
                            col_d   = col_q + 1'b1;
                            addr_d  = map_addr;
                            state_d = StMapWait;
                        end
                    end else begin
                        px_d = px_q + 1'b1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk100) begin
        if (reset) begin
            state_q <= StIdle;
            vpos_q  <= '0;
            col_q   <= '0;
            word_q  <= 1'b0;
            px_q    <= '0;
            char_q  <= '0;
            addr_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            vpos_q  <= vpos_d;
            col_q   <= col_d;
            word_q  <= word_d;
            px_q    <= px_d;
            char_q  <= char_d;
            addr_q  <= addr_d;
            wait_q  <= wait_d;
        end
    end

    tile_row_shifter #(
        .BPP (BPP)
    ) u_shifter (
        .clk100     (clk100),
        .reset      (reset),
        .load_i     (state_q == StTileRd),
        .word_sel_i (word_q),
        .din_i      (ram_din),
        .hflip_i    (char_q[HFLIP_BIT]),
        .px_i       (px_q),
        .pix_o      (pix)
    );

    assign busy       = (state_q != StIdle) && (state_q != StDone);
    assign line_done  = (state_q == StDone);
    assign ram_addr   = addr_q;
    assign ram_ce     = busy;
    assign ram_oe     = busy;
    assign ram_we     = 1'b0;
    assign ram_lb     = 1'b1;
    assign ram_hb     = 1'b1;
    assign fifo_wrreq = (state_q == StPush) && !fifo_full;
    assign fifo_data  = (state_q == StPush) ? pack_fifo_data(char_q[PAL_MSB:PAL_LSB], pix) : '0;

endmodule

// File: doc/tile_fetch_engine.md
# tile_fetch_engine

Parametrised background line fetcher in the clk100 domain. It replaces the fixed 100-tile, debug-pattern fetch loop. On a line-start request it walks one row of the character map in SRAM and fetches each tile's pattern words. It expands them to BPP-bit pixel indices and pushes one 16-bit entry per pixel into the write side of the clk100→clk40 line FIFO, honouring the FIFO's full flag.

## Interface
Parameters:
- BPP, 4: bits per pixel; legal values 2 or 4. Words per tile row WPR = BPP/2.
- TILES_PER_LINE, 100: tiles fetched per line, 1..MAP_STRIDE.
- TILE_ROWS, 8: pixel rows per tile; power of two, 2..16.
- MAP_STRIDE, 128: map words per tile row; power of two.
- MAP_BASE, 18'h00000: SRAM word address of the character map.
- TILE_BASE, 18'h20000: SRAM word address of the tile pattern data.

Ports:
- clk100  in  1  system/RAM clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle line request (hsyncStarting & nextFrameActive)
- vpos  in  10  line number to fetch; sampled with start
- busy  out  1  high from accepted start until line_done
- line_done  out  1  one-cycle pulse after the last pixel is written
- ram_addr  out  18  SRAM word address
- ram_din  in  16  SRAM read data
- ram_ce, ram_oe  out  1  SRAM enables, high while busy
- ram_we  out  1  constant 0
- ram_lb, ram_hb  out  1  constant 1
- fifo_data  out  16  pixel entry: {8'h00, pal[3:0], pix zero-extended to 4}
- fifo_wrreq  out  1  FIFO write strobe
- fifo_full  in  1  FIFO wrfull

## Operation
- Reset values: busy=0, line_done=0, ram_addr=0, ram_ce=0, ram_oe=0, fifo_wrreq=0, fifo_data=0, state IDLE.
- Character word: T=[8:0] tile id; pal=[15:12]; [11:9] reserved except under the flip feature.
- Map address for column c: MAP_BASE + (vpos/TILE_ROWS)*MAP_STRIDE + c. Truncate to 18 bits.
- Tile word w: TILE_BASE + T*TILE_ROWS*WPR + (vpos%TILE_ROWS)*WPR + w. Truncate to 18 bits.
- Pixel order is MSB first. Pixel 0 is word0[15:16-BPP]. Word0 supplies pixels 0..(16/BPP-1) and word1 supplies the rest.
- States:
  - IDLE: on start, latch vpos, c=0, drive map address, ce=oe=1 → MAP_WAIT.
  - MAP_WAIT → MAP_RD.
  - MAP_RD: capture char, drive tile word 0 → TILE_WAIT.
  - TILE_WAIT → TILE_RD.
  - TILE_RD: capture word w. If w<WPR-1, drive word w+1 → TILE_WAIT. Otherwise → PUSH with px=0.
  - PUSH: present pixel px. It is written only on a cycle where fifo_full=0; px advances only on a write. After px=7 is written: if c=TILES_PER_LINE-1 → DONE, else c+1, drive next map address → MAP_WAIT.
  - DONE: ce=oe=0, line_done=1, busy=0 → IDLE.
- fifo_wrreq = (state==PUSH) & ~fifo_full. It never asserts while fifo_full is high. No pixel is dropped or duplicated.
- start while busy is ignored and does not restart the line.
- reset mid-line: return to IDLE next edge with all outputs at reset values. A partial line remains in the FIFO; flushing it is the FIFO owner's job.
- vpos mid-line has no effect. Only the latched copy is used.

## Timing
- SRAM read latency: the address is registered in one cycle, held through a wait cycle, and ram_din is captured at the end of the second cycle.
- Per tile without backpressure: 2 (map) + 2*WPR (pattern) + 8 (push) cycles. This is 14 cycles at BPP=4 and 12 at BPP=2.
- Full line at defaults: 1400 cycles from the start edge to the last write, and line_done on cycle 1401.
- ram_addr for column 0 is valid the cycle after start.
- Each cycle fifo_full is high adds exactly one cycle to the line.

## Configuration
- TILE_FLIP_EN defined:
  - char bit 9 = horizontal flip: pixel order within the 8-pixel row is reversed.
  - char bit 10 = vertical flip: the row term uses (TILE_ROWS-1 - vpos%TILE_ROWS).
- TILE_FLIP_EN undefined: bits 9 and 10 are ignored and no flip logic is built.

## Structure
- Shared package tile_pkg holds:
  - the state enum;
  - char-word field positions (TILE_ID_LSB/MSB, PAL_LSB/MSB, HFLIP_BIT, VFLIP_BIT);
  - the SRAM read wait count;
  - the fifo_data packing function.
- One sub-module, tile_row_shifter: loads WPR pattern words and emits pixel px, applying hflip when enabled.
- Address arithmetic and the FSM live in the top module.

## Test plan
- Default parameters, vpos=17, map row 2 char[c]=c, tile words ramp; no backpressure.
  - Map reads hit 0x100..0x163.
  - Exactly 800 writes.
  - line_done on cycle 1401.
- fifo_full held high for 20 cycles in the middle of tile 3.
  - wrreq stays low for those 20 cycles.
  - Pixel sequence is identical to the no-stall run.
  - line_done is 20 cycles late.
- BPP=2, char=0xA005, vpos=3.
  - Tile read at TILE_BASE+43.
  - Word 0xE400 yields pixels 3,2,1,0,0,0,0,0.
  - fifo_data=0x00A3 for the first pixel.
- start pulsed at cycles 0 and 50, then reset asserted at cycle 300.
  - Second start is ignored.
  - After reset: ce=oe=wrreq=busy=0 next cycle.
  - A fresh start restarts at column 0.
- TILE_FLIP_EN, char bits 9+10 set, vpos=1.
  - Row term = 6.
  - Pixel order is reversed versus an unflipped reference.
- TILES_PER_LINE=1, MAP_STRIDE=128, vpos=1023.
  - Map address 0x3F80.
  - Exactly 8 writes.
  - busy falls with line_done.
